serial_adder: RTL and testbench



---
 rtl/serial_adder_pkg.sv | 17 +
 rtl/serial_adder_full_adder.sv | 13 +
 rtl/serial_adder.sv | 123 ++++++++++++
 tb/tb_serial_adder.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
package serial_adder_pkg;

  localparam int SA_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } sa_state_t;

  // One extra bit so the counter can hold WIDTH-1 for any legal WIDTH.
  function automatic int sa_cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/serial_adder_full_adder.sv
// Single-bit full adder cell used for the per-bit arithmetic of serial_adder.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b ^ c;
  assign carry = (a & b) | (c & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one bit per clock through a full_adder cell, LSB first.
// Optional signed-overflow output enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = SA_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
`ifdef SERIAL_ADDER_OVF_EN
  output logic             ovf,
`endif
  output logic             cout
);

  localparam int             CW   = sa_cnt_width(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  sa_state_t        r_state;
  sa_state_t        w_next;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_sum_sr;
  logic             r_carry_q;
  logic [CW-1:0]    r_cnt;
  logic             r_done;
  logic [WIDTH-1:0] r_sum_out;
  logic             r_cout;
  logic             w_sum_bit;
  logic             w_carry_bit;

  full_adder u_fa (
    .a     (r_a_sr[0]),
    .b     (r_b_sr[0]),
    .c     (r_carry_q),
    .sum   (w_sum_bit),
    .carry (w_carry_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = SHIFT;
      SHIFT:   if (r_cnt == LAST) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sr    <= '0;
      r_b_sr    <= '0;
      r_sum_sr  <= '0;
      r_carry_q <= 1'b0;
      r_cnt     <= '0;
      r_done    <= 1'b0;
      r_sum_out <= '0;
      r_cout    <= 1'b0;
    end else begin
      r_done <= (r_state == DONE);
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a_sr    <= a_in;
            r_b_sr    <= b_in;
            r_carry_q <= cin;
            r_cnt     <= '0;
          end
        end
        SHIFT: begin
          // Sum bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts.
          r_sum_sr  <= {w_sum_bit, r_sum_sr[WIDTH-1:1]};
          r_carry_q <= w_carry_bit;
          r_a_sr    <= r_a_sr >> 1;
          r_b_sr    <= r_b_sr >> 1;
          r_cnt     <= r_cnt + CW'(1);
        end
        DONE: begin
          r_sum_out <= r_sum_sr;
          r_cout    <= r_carry_q;
        end
        default: ;
      endcase
    end
  end

`ifdef SERIAL_ADDER_OVF_EN
  logic r_carry_msb;
  logic r_ovf;

  // Carry into the MSB is the carry register while the last bit is processed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_carry_msb <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      if (r_state == SHIFT && r_cnt == LAST) r_carry_msb <= r_carry_q;
      if (r_state == DONE) r_ovf <= r_carry_msb ^ r_carry_q;
    end
  end

  assign ovf = r_ovf;
`endif

  assign busy    = (r_state == SHIFT);
  assign done    = r_done;
  assign sum_out = r_sum_out;
  assign cout    = r_cout;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at WIDTH=8 and WIDTH=16; define
// SERIAL_ADDER_OVF_EN to also check the ovf output.
module tb_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        start8, cin8, busy8, done8, cout8;
  logic [7:0]  a8, b8, sum8;
  logic        start16, cin16, busy16, done16, cout16;
  logic [15:0] a16, b16, sum16;
`ifdef SERIAL_ADDER_OVF_EN
  logic        ovf8, ovf16;
`endif

  int errors = 0;
  int checks = 0;

  // Entry layout: {ovf, cout, sum[31:0]}
  logic [33:0] exp8_q[$];
  logic [33:0] exp16_q[$];

  serial_adder #(.WIDTH(8)) dut8 (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start8),
    .a_in    (a8),
    .b_in    (b8),
    .cin     (cin8),
    .busy    (busy8),
    .done    (done8),
    .sum_out (sum8),
`ifdef SERIAL_ADDER_OVF_EN
    .ovf     (ovf8),
`endif
    .cout    (cout8)
  );

  serial_adder #(.WIDTH(16)) dut16 (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start16),
    .a_in    (a16),
    .b_in    (b16),
    .cin     (cin16),
    .busy    (busy16),
    .done    (done16),
    .sum_out (sum16),
`ifdef SERIAL_ADDER_OVF_EN
    .ovf     (ovf16),
`endif
    .cout    (cout16)
  );

  // Reference: plain integer addition; overflow from operand/result signs.
  function automatic logic [33:0] ref_add(input int w, input logic [31:0] a,
                                          input logic [31:0] b, input logic c);
    logic [32:0] full;
    logic [31:0] mask;
    logic        ov;
    full = {1'b0, a} + {1'b0, b} + {32'd0, c};
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    ov   = (a[w-1] == b[w-1]) && (full[w-1] != a[w-1]);
    return {ov, full[w], full[31:0] & mask};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitors: pop one expected result per done pulse.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done8 === 1'b1) begin
      if (exp8_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL done8_unexpected: got done with empty expected queue");
      end else begin
        logic [33:0] e;
        e = exp8_q.pop_front();
        check("sum8", {24'd0, sum8}, e[31:0]);
        check("cout8", {31'd0, cout8}, {31'd0, e[32]});
`ifdef SERIAL_ADDER_OVF_EN
        check("ovf8", {31'd0, ovf8}, {31'd0, e[33]});
`endif
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1 && done16 === 1'b1) begin
      if (exp16_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL done16_unexpected: got done with empty expected queue");
      end else begin
        logic [33:0] e;
        e = exp16_q.pop_front();
        check("sum16", {16'd0, sum16}, e[31:0]);
        check("cout16", {31'd0, cout16}, {31'd0, e[32]});
`ifdef SERIAL_ADDER_OVF_EN
        check("ovf16", {31'd0, ovf16}, {31'd0, e[33]});
`endif
      end
    end
  end

  task automatic wait_done8();
    int n = 0;
    while (done8 !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      checks++;
      errors++;
      $display("FAIL done8_timeout: got no done within 40 cycles");
    end
  endtask

  task automatic wait_done16();
    int n = 0;
    while (done16 !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      checks++;
      errors++;
      $display("FAIL done16_timeout: got no done within 40 cycles");
    end
  endtask

  // Called at a negedge with the DUT idle; operands scrambled after acceptance.
  task automatic add8(input logic [7:0] a, input logic [7:0] b, input logic c, input int gap);
    start8 = 1'b1; a8 = a; b8 = b; cin8 = c;
    exp8_q.push_back(ref_add(8, {24'd0, a}, {24'd0, b}, c));
    @(negedge clk);
    start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
    wait_done8();
    repeat (gap) @(negedge clk);
  endtask

  task automatic add16(input logic [15:0] a, input logic [15:0] b, input logic c, input int gap);
    start16 = 1'b1; a16 = a; b16 = b; cin16 = c;
    exp16_q.push_back(ref_add(16, {16'd0, a}, {16'd0, b}, c));
    @(negedge clk);
    start16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom);
    wait_done16();
    repeat (gap) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy8", {31'd0, busy8}, 32'd0);
    check("rst_done8", {31'd0, done8}, 32'd0);
    check("rst_sum8", {24'd0, sum8}, 32'd0);
    check("rst_cout8", {31'd0, cout8}, 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
    check("rst_ovf8", {31'd0, ovf8}, 32'd0);
`endif
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Latency: start accepted at edge 0, busy cycles 1..8, done at cycle 10.
    start8 = 1'b1; a8 = 8'h0F; b8 = 8'h01; cin8 = 1'b0;
    exp8_q.push_back(ref_add(8, 32'h0F, 32'h01, 1'b0));
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      start8 = 1'b0;
      check($sformatf("busy8_cyc%0d", k), {31'd0, busy8}, {31'd0, (k >= 1 && k <= 8)});
      check($sformatf("done8_cyc%0d", k), {31'd0, done8}, {31'd0, (k == 10)});
    end

    add8(8'hFF, 8'h01, 1'b0, 1);
    add8(8'hFF, 8'hFF, 1'b1, 1);
    add8(8'h7F, 8'h01, 1'b0, 0);
    add8(8'h80, 8'h80, 1'b0, 2);
    add8(8'hFF, 8'h01, 1'b0, 1);

    // A start during SHIFT must be ignored.
    start8 = 1'b1; a8 = 8'h05; b8 = 8'h03; cin8 = 1'b0;
    exp8_q.push_back(ref_add(8, 32'h05, 32'h03, 1'b0));
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    start8 = 1'b1; a8 = 8'hAA; b8 = 8'h11;
    @(negedge clk);
    start8 = 1'b0;
    wait_done8();
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check("done8_single", {31'd0, done8}, 32'd0);
    end
    add8(8'h12, 8'h34, 1'b1, 1);

    // Reset mid-SHIFT aborts the operation without a result.
    start8 = 1'b1; a8 = 8'h33; b8 = 8'h44; cin8 = 1'b0;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy8", {31'd0, busy8}, 32'd0);
    check("abort_done8", {31'd0, done8}, 32'd0);
    check("abort_sum8", {24'd0, sum8}, 32'd0);
    check("abort_cout8", {31'd0, cout8}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check("abort_no_done8", {31'd0, done8}, 32'd0);
    end
    add8(8'h20, 8'h22, 1'b0, 1);

    for (int i = 0; i < 1000; i++)
      add8(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 3));
    for (int i = 0; i < 1000; i++)
      add16(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 3));

    repeat (3) @(negedge clk);
    check("exp8_q_drained", exp8_q.size(), 32'd0);
    check("exp16_q_drained", exp16_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
